// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel-RAM read port and encoder handshake between the frame sequencer and its neighbours.
interface ws2812_frame_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [23:0]       mem_data;
   logic              px_valid;
   logic [23:0]       px_data;
   logic              px_ready;
   logic              enc_idle;

   // Sequencer side: drives the RAM read port and offers pixels to the encoder.
   modport master (
      output mem_rd, mem_addr, px_valid, px_data,
      input  mem_data, px_ready, enc_idle
   );

   // RAM/encoder side.
   modport slave (
      input  mem_rd, mem_addr, px_valid, px_data,
      output mem_data, px_ready, enc_idle
   );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Frame-level WS2812 controller: reads frame_len GRB words from the pixel RAM,
// hands them one by one to the bit encoder, waits for the encoder to empty,
// holds the line for the latch gap and pulses done.
module ws2812_frame_sequencer #(
   parameter int ADDR_W       = 8,
   parameter int RESET_CYCLES = 800
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [ADDR_W-1:0]            frame_len_i,
   output logic                         busy_o,
   output logic                         done_o,
   ws2812_frame_sequencer_if.master     bus_if
);

   localparam int CNT_W = $clog2(RESET_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PRESENT,
      S_DRAIN,
      S_LATCH
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] len_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              px_valid_q;
   logic [23:0]       px_data_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W-1:0] idx_inc_d;
   logic              last_px_d;
   logic [CNT_W-1:0]  cnt_dec_d;

   // Next pixel address, last-pixel flag and decremented latch count.
   always_comb begin
      idx_inc_d = idx_q + ADDR_W'(1);
      last_px_d = (idx_q == len_q - ADDR_W'(1));
      cnt_dec_d = cnt_q - CNT_W'(1);
   end

   // Frame FSM with registered outputs; abort funnels every active state into DRAIN.
   always_ff @(posedge clk) begin
      // NOTE: the reset is synchronous, so it is just the first branch of the clocked block.
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         px_valid_q <= 1'b0;
         px_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: defaults first make done and mem_rd single-cycle strobes without per-state clears.
         done_q   <= 1'b0;
         mem_rd_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && (frame_len_i != '0)) begin
                  len_q      <= frame_len_i;
                  idx_q      <= '0;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_FETCH: begin
               state_q <= abort_i ? S_DRAIN : S_LOAD;
            end
            S_LOAD: begin
               if (abort_i) begin
                  state_q <= S_DRAIN;
               end else begin
                  px_data_q  <= bus_if.mem_data;
                  px_valid_q <= 1'b1;
                  state_q    <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               // An abort wins over a simultaneous px_ready: that pixel is not sent.
               if (abort_i) begin
                  px_valid_q <= 1'b0;
                  state_q    <= S_DRAIN;
               end else if (bus_if.px_ready) begin
                  px_valid_q <= 1'b0;
                  if (last_px_d) begin
                     state_q <= S_DRAIN;
                  end else begin
                     idx_q      <= idx_inc_d;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= idx_inc_d;
                     state_q    <= S_FETCH;
                  end
               end
            end
            S_DRAIN: begin
               if (!abort_i && bus_if.enc_idle) begin
                  cnt_q   <= CNT_W'(RESET_CYCLES - 1);
                  state_q <= S_LATCH;
               end
            end
            S_LATCH: begin
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_if.mem_rd   = mem_rd_q;
   assign bus_if.mem_addr = mem_addr_q;
   assign bus_if.px_valid = px_valid_q;
   assign bus_if.px_data  = px_data_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Self-checking bench for ws2812_frame_sequencer: a RAM/encoder environment records
// every read, handshake and status edge with cycle stamps, and each frame is checked
// against the transaction-level expectation (RAM order, addresses, latencies, latch gap).
module tb_ws2812_frame_sequencer;

   localparam int ADDR_W = 8;
   localparam int R      = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_i;
   logic              abort_i;
   logic [ADDR_W-1:0] frame_len_i;
   logic              busy_o;
   logic              done_o;

   ws2812_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   ws2812_frame_sequencer #(
      .ADDR_W       (ADDR_W),
      .RESET_CYCLES (R)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .frame_len_i (frame_len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .bus_if      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [23:0] ram [256];

   // Environment controls: 0 = ready tied high, 1 = ready after N valid cycles, 2 = random.
   int ready_mode  = 0;
   int ready_stall = 0;
   int idle_low    = 0;

   // Sample index c is the cycle that ends at clock edge c.
   int          cyc = -1;
   logic [23:0] hs_data_q [$];
   int          hs_cyc_q  [$];
   int          rd_addr_q [$];
   int          rd_cyc_q  [$];
   int          vrise_q   [$];
   int          done_q    [$];
   int          brise_q   [$];
   int          bfall_q   [$];
   bit          idle_hist [$];

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic clear_q();
      hs_data_q.delete();
      hs_cyc_q.delete();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      vrise_q.delete();
      done_q.delete();
      brise_q.delete();
      bfall_q.delete();
   endtask

   // RAM with one-cycle read latency, encoder model and protocol monitor.
   initial begin
      int          valid_age  = 0;
      int          idle_left  = 0;
      bit          prev_rd    = 1'b0;
      logic [ADDR_W-1:0] prev_addr = '0;
      bit          prev_valid = 1'b0;
      bit          prev_busy  = 1'b0;
      bit          prev_done  = 1'b0;
      bit          exp_hold   = 1'b0;
      bit          exp_drop   = 1'b0;
      bit          exp_zero   = 1'b0;
      logic [23:0] held_data  = '0;
      bus.mem_data = '0;
      bus.px_ready = 1'b0;
      bus.enc_idle = 1'b1;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (exp_zero)
            check("reset_outputs", {bus.mem_rd, bus.mem_addr, bus.px_valid, bus.px_data, busy_o, done_o}, 0);
         if (exp_hold) begin
            check("px_valid_hold", bus.px_valid, 1);
            check("px_data_hold", bus.px_data, held_data);
         end
         if (exp_drop)
            check("px_valid_drop", bus.px_valid, 0);
         if (done_o)
            check("done_one_cycle", prev_done, 0);

         if (bus.mem_rd) begin
            rd_addr_q.push_back(int'(bus.mem_addr));
            rd_cyc_q.push_back(cyc);
         end
         if (bus.px_valid && !prev_valid) vrise_q.push_back(cyc);
         if (done_o) done_q.push_back(cyc);
         if (busy_o && !prev_busy) brise_q.push_back(cyc);
         if (!busy_o && prev_busy) bfall_q.push_back(cyc);
         prev_valid = bus.px_valid;
         prev_busy  = busy_o;
         prev_done  = done_o;

         // Read data is only meaningful in the cycle after the strobe; garbage otherwise.
         bus.mem_data = prev_rd ? ram[prev_addr] : 24'($urandom);
         prev_rd   = bus.mem_rd;
         prev_addr = bus.mem_addr;

         case (ready_mode)
            0:       bus.px_ready = 1'b1;
            1:       bus.px_ready = (valid_age >= ready_stall);
            default: bus.px_ready = 1'($urandom_range(0, 1));
         endcase
         valid_age = bus.px_valid ? valid_age + 1 : 0;

         bus.enc_idle = (idle_left == 0);
         idle_hist.push_back(bus.enc_idle);
         if (idle_left > 0) idle_left--;

         #2;
         // Predict what the coming edge must do, from the values the DUT will sample.
         exp_zero  = !rst_n;
         exp_hold  = rst_n && bus.px_valid && !bus.px_ready && !abort_i;
         exp_drop  = rst_n && bus.px_valid && (bus.px_ready || abort_i);
         held_data = bus.px_data;
         if (rst_n && bus.px_valid && bus.px_ready && !abort_i) begin
            hs_data_q.push_back(bus.px_data);
            hs_cyc_q.push_back(cyc);
            idle_left = idle_low;
         end
      end
   end

   // Run one frame starting at the current cycle and check it against the expected transaction list.
   task automatic frame(input string tag, input int len, input int rmode, input int rstall,
                        input int ilow, input int abort_px, input int mid_start);
      int  s;
      int  abort_cyc;
      int  n_exp;
      int  rd_exp;
      int  drain_from;
      int  d;
      int  exp_done;
      bit  seen_done;
      clear_q();
      ready_mode  = rmode;
      ready_stall = rstall;
      idle_low    = ilow;
      frame_len_i = ADDR_W'(len);
      start_i     = 1'b1;
      s           = cyc;
      abort_cyc   = -1;
      seen_done   = 1'b0;
      for (int k = 1; k <= 5000; k++) begin
         step();
         start_i = (k == mid_start);
         if (k == mid_start) frame_len_i = ADDR_W'($urandom_range(1, 200));
         abort_i = 1'b0;
         if (abort_px >= 0 && abort_cyc < 0 && hs_data_q.size() == abort_px && bus.px_valid) begin
            abort_i   = 1'b1;
            abort_cyc = cyc;
         end
         if (done_o) begin
            seen_done = 1'b1;
            break;
         end
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      check({tag, "_done_seen"}, seen_done, 1);

      n_exp  = (abort_px >= 0) ? abort_px : len;
      rd_exp = (abort_px >= 0) ? abort_px + 1 : len;
      check({tag, "_hs_count"}, hs_data_q.size(), n_exp);
      for (int i = 0; i < hs_data_q.size() && i < n_exp; i++)
         check($sformatf("%s_px%0d_data", tag, i), hs_data_q[i], ram[i]);
      check({tag, "_rd_count"}, rd_addr_q.size(), rd_exp);
      for (int i = 0; i < rd_addr_q.size(); i++)
         check($sformatf("%s_rd%0d_addr", tag, i), rd_addr_q[i], i);
      if (rd_cyc_q.size() > 0) check({tag, "_first_rd_cycle"}, rd_cyc_q[0], s + 1);
      if (vrise_q.size() > 0) check({tag, "_first_valid_cycle"}, vrise_q[0], s + 3);
      for (int i = 0; i < hs_cyc_q.size(); i++) begin
         if (i + 1 < rd_cyc_q.size())
            check($sformatf("%s_rd%0d_latency", tag, i + 1), rd_cyc_q[i + 1], hs_cyc_q[i] + 1);
         if (i + 1 < vrise_q.size())
            check($sformatf("%s_valid%0d_latency", tag, i + 1), vrise_q[i + 1], hs_cyc_q[i] + 3);
      end

      if (abort_cyc >= 0)            drain_from = abort_cyc;
      else if (hs_cyc_q.size() > 0)  drain_from = hs_cyc_q[hs_cyc_q.size() - 1];
      else                           drain_from = s;
      d = drain_from + 1;
      while (d < idle_hist.size() && !idle_hist[d]) d++;
      exp_done = d + R + 1;
      check({tag, "_done_count"}, done_q.size(), 1);
      if (done_q.size() > 0) check({tag, "_done_cycle"}, done_q[0], exp_done);
      check({tag, "_busy_rises"}, brise_q.size(), 1);
      if (brise_q.size() > 0) check({tag, "_busy_rise_cycle"}, brise_q[0], s + 1);
      check({tag, "_busy_falls"}, bfall_q.size(), 1);
      if (bfall_q.size() > 0) check({tag, "_busy_fall_cycle"}, bfall_q[0], exp_done);
   endtask

   initial begin
      rst_n       = 1'b0;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      frame_len_i = '0;
      for (int i = 0; i < 256; i++) ram[i] = 24'($urandom);
      ram[0] = 24'h00FF00;
      ram[1] = 24'hFF0000;
      ram[2] = 24'h0000FF;

      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("post_reset_outputs", {bus.mem_rd, bus.mem_addr, bus.px_valid, bus.px_data, busy_o, done_o}, 0);

      // Basic frame, ready and enc_idle high.
      frame("basic", 3, 0, 0, 0, -1, 0);
      repeat (3) step();

      // Backpressure: 50 low-ready cycles per pixel.
      frame("backpressure", 4, 1, 50, 0, -1, 0);
      repeat (3) step();

      // Encoder still busy for 30 cycles after the last handshake.
      frame("drain", 3, 0, 0, 30, -1, 0);
      repeat (3) step();

      // Abort while presenting pixel 2 with ready high in the same cycle.
      frame("abort", 5, 0, 0, 0, 2, 0);
      repeat (3) step();

      // Zero-length start is ignored.
      clear_q();
      frame_len_i = '0;
      start_i     = 1'b1;
      step();
      start_i = 1'b0;
      repeat (20) step();
      check("len0_busy_rises", brise_q.size(), 0);
      check("len0_done_count", done_q.size(), 0);
      check("len0_rd_count", rd_addr_q.size(), 0);

      // Start pulsed mid-frame must not disturb the running frame.
      frame("midstart", 6, 2, 0, 2, -1, 7);
      repeat (3) step();

      // Start in the done cycle begins the next frame on the following edge.
      frame("chain_a", 2, 0, 0, 0, -1, 0);
      frame("chain_b", 3, 2, 0, 1, -1, 0);
      repeat (3) step();

      // Reset asserted for one cycle while in LOAD.
      clear_q();
      frame_len_i = ADDR_W'(4);
      start_i     = 1'b1;
      step();
      start_i = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (15) step();
      check("midreset_done_count", done_q.size(), 0);
      check("midreset_busy", busy_o, 0);
      check("midreset_px_valid", bus.px_valid, 0);
      frame("after_reset", 4, 2, 0, 1, -1, 0);
      repeat (3) step();

      // Randomised frames.
      for (int n = 0; n < 4; n++) begin
         frame($sformatf("rand%0d", n), $urandom_range(1, 12), 2, 0, $urandom_range(0, 4), -1,
               $urandom_range(0, 20));
         repeat (2) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
